rst_seq_ctrl: RTL and testbench

- Reset sequencer and arbiter shared by several reset requesters: host software, link-down detect and acquisition watchdog.
- Each granted request runs one full timed sequence: pre-delay, active-low reset pulse to the downstream datapath, post-delay, one-cycle PCIe FIFO reset trigger, hold-off.
- Requests that arrive while a sequence runs are queued and serviced one at a time in fixed priority. No sequence is ever cut short or restarted.

---
 rtl/rst_seq_pkg.sv | 19 +
 rtl/rst_seq_arb.sv | 62 ++++++
 rtl/rst_seq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state type, counter width and helpers for the reset sequencer
package rst_seq_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRE    = 3'd1,
        ASSERT = 3'd2,
        POST   = 3'd3,
        HOLD   = 3'd4
    } state_t;

    // Counter that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rst_seq_arb.sv
// rtl/rst_seq_arb.sv - pending request latch with fixed-priority lowest-index select (RST_SEQ_STATS_EN adds merge)
module rst_seq_arb
    import rst_seq_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               grant,
    output logic               any_pending,
    output logic [ID_W-1:0]    sel_id
`ifdef RST_SEQ_STATS_EN
    ,
    output logic               merge
`endif
);

    logic [NUM_REQ-1:0] pending_q;
    logic [NUM_REQ-1:0] pending_d;
    logic [NUM_REQ-1:0] sel_mask;
    logic [NUM_REQ-1:0] clr_mask;
    logic               found;

    // Lowest set index wins; sel_mask is the one-hot of that winner.
    always_comb begin
        sel_id   = '0;
        sel_mask = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pending_q[i] && !found) begin
                found       = 1'b1;
                sel_id      = ID_W'(i);
                sel_mask[i] = 1'b1;
            end
        end
    end

    // Granted bit clears on the grant edge; new pulses (even for that same id) are kept.
    always_comb begin
        clr_mask  = grant ? sel_mask : '0;
        pending_d = (pending_q & ~clr_mask) | req;
    end

    // Pending register; reset discards every outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign any_pending = |pending_q;

`ifdef RST_SEQ_STATS_EN
    // A pulse landing on a bit that is still waiting is folded into the earlier request.
    assign merge = |(req & pending_q & ~clr_mask);
`endif

endmodule

// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - reset sequencer top: FSM, delay counter, registered outputs (RST_SEQ_STATS_EN adds seq_cnt/drop_flag)
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int               NUM_REQ   = 3,
    parameter logic [CNT_W-1:0] PRE_DLY   = 32'd5000,
    parameter logic [CNT_W-1:0] PULSE_LEN = 32'd100,
    parameter logic [CNT_W-1:0] FIFO_DLY  = 32'd2900,
    parameter logic [CNT_W-1:0] HOLDOFF   = 32'd2000,
    localparam int              ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic               busy,
    output logic [ID_W-1:0]    grant_id,
    output logic               rst_n_out,
    output logic               fifo_rst_trig,
    output logic               done,
    output logic [ID_W-1:0]    done_id
`ifdef RST_SEQ_STATS_EN
    ,
    output logic [15:0]        seq_cnt,
    output logic               drop_flag
`endif
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic             rst_n_q, rst_n_d;
    logic             fifo_q, fifo_d;
    logic             done_q, done_d;
    logic [ID_W-1:0]  done_id_q, done_id_d;
    logic             grant;
    logic             any_pending;
    logic [ID_W-1:0]  sel_id;

`ifdef RST_SEQ_STATS_EN
    logic             merge;
    logic [15:0]      seq_cnt_q, seq_cnt_d;
    logic             drop_q, drop_d;
`endif

    rst_seq_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .any_pending (any_pending),
        .sel_id      (sel_id)
`ifdef RST_SEQ_STATS_EN
        ,
        .merge       (merge)
`endif
    );

    // Next-state and output decode; each phase runs to its terminal count, nothing aborts it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        grant_id_d = grant_id_q;
        rst_n_d    = rst_n_q;
        fifo_d     = 1'b0;
        done_d     = 1'b0;
        done_id_d  = done_id_q;
        grant      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && any_pending) begin
                    grant      = 1'b1;
                    grant_id_d = sel_id;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    state_d    = PRE;
                end
            end
            PRE: begin
                if (cnt_q == PRE_DLY - 1'b1) begin
                    cnt_d   = '0;
                    rst_n_d = 1'b0;
                    state_d = ASSERT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ASSERT: begin
                if (cnt_q == PULSE_LEN - 1'b1) begin
                    cnt_d   = '0;
                    rst_n_d = 1'b1;
                    state_d = POST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            POST: begin
                if (cnt_q == FIFO_DLY - 1'b1) begin
                    cnt_d   = '0;
                    fifo_d  = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                // Hold-off starts counting in the strobe cycle itself, so done lands HOLDOFF+1 after it.
                if (cnt_q == HOLDOFF) begin
                    cnt_d     = '0;
                    done_d    = 1'b1;
                    done_id_d = grant_id_q;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
                rst_n_d = 1'b1;
            end
        endcase
    end

    // State, counter and output registers; reset releases rst_n_out immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            grant_id_q <= '0;
            rst_n_q    <= 1'b1;
            fifo_q     <= 1'b0;
            done_q     <= 1'b0;
            done_id_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            grant_id_q <= grant_id_d;
            rst_n_q    <= rst_n_d;
            fifo_q     <= fifo_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
        end
    end

    assign busy          = busy_q;
    assign grant_id      = grant_id_q;
    assign rst_n_out     = rst_n_q;
    assign fifo_rst_trig = fifo_q;
    assign done          = done_q;
    assign done_id       = done_id_q;

`ifdef RST_SEQ_STATS_EN
    // Completed-sequence count (saturating) and sticky merged-request flag.
    always_comb begin
        seq_cnt_d = done_d ? sat_inc16(seq_cnt_q) : seq_cnt_q;
        drop_d    = drop_q | merge;
    end

    // Statistics registers, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_cnt_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            seq_cnt_q <= seq_cnt_d;
            drop_q    <= drop_d;
        end
    end

    assign seq_cnt   = seq_cnt_q;
    assign drop_flag = drop_q;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb/tb_rst_seq_ctrl.sv - directed and random checks of rst_seq_ctrl against a timeline model
module tb_rst_seq_ctrl;

    localparam int NR  = 3;
    localparam int PRE = 10;
    localparam int PUL = 4;
    localparam int FIF = 6;
    localparam int HLD = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic       en  = 1'b0;
    logic       busy;
    logic [1:0] grant_id;
    logic       rst_n_out;
    logic       fifo_rst_trig;
    logic       done;
    logic [1:0] done_id;
`ifdef RST_SEQ_STATS_EN
    logic [15:0] seq_cnt;
    logic        drop_flag;
`endif

    always #5 clk = ~clk;

    rst_seq_ctrl #(
        .NUM_REQ   (NR),
        .PRE_DLY   (32'(PRE)),
        .PULSE_LEN (32'(PUL)),
        .FIFO_DLY  (32'(FIF)),
        .HOLDOFF   (32'(HLD))
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .en            (en),
        .busy          (busy),
        .grant_id      (grant_id),
        .rst_n_out     (rst_n_out),
        .fifo_rst_trig (fifo_rst_trig),
        .done          (done),
        .done_id       (done_id)
`ifdef RST_SEQ_STATS_EN
        ,
        .seq_cnt       (seq_cnt),
        .drop_flag     (drop_flag)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: each granted sequence is a set of absolute edge numbers derived from its grant edge.
    int         n      = 0;
    logic [2:0] mp     = 3'b000;
    bit         act    = 1'b0;
    int         g      = 0;
    int         f_at   = 0;
    int         d_at   = 0;
    int         gid    = 0;
    int         ld_id  = 0;
    int         m_cnt  = 0;
    bit         m_drop = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, n);
        end
    endtask

    task automatic model_reset();
        act    = 1'b0;
        mp     = 3'b000;
        ld_id  = 0;
        m_cnt  = 0;
        m_drop = 1'b0;
    endtask

    task automatic model_edge(input logic [2:0] r, input logic e);
        n++;
        if (e && mp != 3'b000 && (!act || n > d_at)) begin
            for (int i = NR - 1; i >= 0; i--) if (mp[i]) gid = i;
            mp[gid] = 1'b0;
            act  = 1'b1;
            g    = n;
            f_at = g + PRE + PUL + FIF;
            d_at = f_at + HLD + 1;
        end
        if (act && n == d_at) begin
            ld_id = gid;
            if (m_cnt < 65535) m_cnt++;
        end
        if ((r & mp) != 3'b000) m_drop = 1'b1;
        mp = mp | r;
    endtask

    task automatic check_all();
        bit eb;
        eb = act && n >= g && n < d_at;
        chk("busy", 32'(busy), 32'(eb));
        if (eb) chk("grant_id", 32'(grant_id), 32'(gid));
        chk("rst_n_out", 32'(rst_n_out), 32'(!(act && n >= g + PRE && n < g + PRE + PUL)));
        chk("fifo_rst_trig", 32'(fifo_rst_trig), 32'(act && n == f_at));
        chk("done", 32'(done), 32'(act && n == d_at));
        if (act && n == d_at) chk("done_id", 32'(done_id), 32'(ld_id));
`ifdef RST_SEQ_STATS_EN
        chk("seq_cnt", 32'(seq_cnt), 32'(m_cnt));
        chk("drop_flag", 32'(drop_flag), 32'(m_drop));
`endif
    endtask

    task automatic cyc(input logic [2:0] r, input logic e);
        req = r;
        en  = e;
        @(posedge clk);
        model_edge(r, e);
        #1;
        check_all();
    endtask

    initial begin
        logic [2:0] r;
        logic       e;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_rst_n_out", 32'(rst_n_out), 32'd1);
        chk("rst_fifo", 32'(fifo_rst_trig), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        rst = 1'b0;
        model_reset();
        repeat (3) cyc(3'b000, 1'b1);

        // Single request from id 1
        cyc(3'b010, 1'b1);
        repeat (30) cyc(3'b000, 1'b1);

        // Two simultaneous requests: id 1 then id 2
        cyc(3'b110, 1'b1);
        repeat (60) cyc(3'b000, 1'b1);

        // id 2 requested while id 0 holds rst_n_out low
        cyc(3'b001, 1'b1);
        repeat (12) cyc(3'b000, 1'b1);
        chk("assert_phase_low", 32'(rst_n_out), 32'd0);
        cyc(3'b100, 1'b1);
        repeat (60) cyc(3'b000, 1'b1);

        // en low holds off the grant; raising it starts on the next edge
        cyc(3'b001, 1'b0);
        repeat (19) cyc(3'b000, 1'b0);
        chk("en_low_idle", 32'(busy), 32'd0);
        cyc(3'b000, 1'b1);
        chk("en_grant_busy", 32'(busy), 32'd1);
        chk("en_grant_id", 32'(grant_id), 32'd0);
        repeat (30) cyc(3'b000, 1'b1);

        // Repeated request for a bit already pending
        cyc(3'b001, 1'b0);
        cyc(3'b001, 1'b0);
        repeat (30) cyc(3'b000, 1'b1);

        // Reset in the middle of the pulse, with another request queued
        cyc(3'b001, 1'b1);
        repeat (5) cyc(3'b000, 1'b1);
        cyc(3'b100, 1'b1);
        repeat (6) cyc(3'b000, 1'b1);
        chk("pre_reset_low", 32'(rst_n_out), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_n_out", 32'(rst_n_out), 32'd1);
        chk("async_busy", 32'(busy), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) cyc(3'b000, 1'b1);

        // Random requests and enable toggling
        e = 1'b1;
        for (int k = 0; k < 2500; k++) begin
            r = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            if ($urandom_range(0, 63) == 0) e = !e;
            cyc(r, e);
        end
        repeat (100) cyc(3'b000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
